// File: rtl/delay_scheduler_pkg.sv
// rtl/delay_scheduler_pkg.sv - FSM state type and default parameters shared by delay_scheduler
package delay_scheduler_pkg;

  localparam int N_CH_DEF  = 3;
  localparam int DLY_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/ds_channel.sv
// rtl/ds_channel.sv - one scheduled channel: latched delay/target, fired flag, output bit
module ds_channel #(
  parameter int DLY_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             launch,
  input  logic             run_en,
  input  logic [DLY_W-1:0] tick,
  input  logic [DLY_W-1:0] dly_in,
  input  logic             init_bit,
  input  logic             tgt_bit,
  output logic             ch_out,
  output logic             fired,
  output logic             fire_now
);

  logic [DLY_W-1:0] dly_q;
  logic             tgt_q;

  assign fire_now = run_en && !fired && (tick == dly_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dly_q  <= '0;
      tgt_q  <= 1'b0;
      fired  <= 1'b0;
      ch_out <= 1'b0;
    end else if (launch) begin
      dly_q  <= dly_in;
      tgt_q  <= tgt_bit;
      fired  <= 1'b0;
      ch_out <= init_bit;
    end else if (fire_now) begin
      ch_out <= tgt_q;
      fired  <= 1'b1;
    end
  end

endmodule

// File: rtl/delay_scheduler.sv
// rtl/delay_scheduler.sv - per-channel delayed value scheduler with optional snapshot
// Snapshot capture is built only when DELAY_SCHEDULER_SNAP_EN is defined.
module delay_scheduler
  import delay_scheduler_pkg::*;
#(
  parameter int N_CH  = N_CH_DEF,
  parameter int DLY_W = DLY_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  abort,
  input  logic [N_CH-1:0]       init_val,
  input  logic [N_CH-1:0]       tgt_val,
  input  logic [N_CH*DLY_W-1:0] ch_dly,
  input  logic [DLY_W-1:0]      snap_dly,
  output logic [N_CH-1:0]       ch_out,
  output logic [N_CH-1:0]       snap_out,
  output logic                  snap_vld,
  output logic                  busy,
  output logic                  done,
  output logic [DLY_W-1:0]      tick
);

  state_t          state, state_nxt;
  logic            launch;
  logic            run_en;
  logic            complete;
  logic            snap_ok;
  logic [N_CH-1:0] fired;
  logic [N_CH-1:0] fire_now;

  assign launch = (state == IDLE) && start && !abort;
  // abort freezes every register in its cycle, so partial results are kept as they were
  assign run_en = (state == RUN) && !abort;

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    ds_channel #(.DLY_W(DLY_W)) u_ch (
      .clk      (clk),
      .rst_n    (rst_n),
      .launch   (launch),
      .run_en   (run_en),
      .tick     (tick),
      .dly_in   (ch_dly[g*DLY_W +: DLY_W]),
      .init_bit (init_val[g]),
      .tgt_bit  (tgt_val[g]),
      .ch_out   (ch_out[g]),
      .fired    (fired[g]),
      .fire_now (fire_now[g])
    );
  end

`ifdef DELAY_SCHEDULER_SNAP_EN
  logic [DLY_W-1:0] snap_dly_q;
  logic             snap_now;

  assign snap_now = run_en && !snap_vld && (tick == snap_dly_q);
  assign snap_ok  = snap_vld || snap_now;

  // snap_out samples the pre-update channel register, so same-cycle events are not seen
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      snap_dly_q <= '0;
      snap_out   <= '0;
      snap_vld   <= 1'b0;
    end else if (launch) begin
      snap_dly_q <= snap_dly;
      snap_vld   <= 1'b0;
    end else if (snap_now) begin
      snap_out   <= ch_out;
      snap_vld   <= 1'b1;
    end
  end
`else
  logic unused_snap_dly;

  assign unused_snap_dly = ^snap_dly;
  assign snap_ok         = 1'b1;
  assign snap_out        = '0;
  assign snap_vld        = 1'b0;
`endif

  assign complete = run_en && (&(fired | fire_now)) && snap_ok;

  // tick stops on the completing cycle so a 2^DLY_W-1 delay never wraps
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick <= '0;
    end else if (launch) begin
      tick <= '0;
    end else if (run_en && !complete) begin
      tick <= tick + DLY_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (launch) state_nxt = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (abort) begin
          state_nxt = IDLE;
        end else if (complete) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: doc/delay_scheduler.md
DELAY_SCHEDULER -- requirements
Module: delay_scheduler

Interface
REQ-001 Parameter N_CH, default 3: number of scheduled channels, 1..16.
REQ-002 Parameter DLY_W, default 8: width of every delay value and of the tick counter.
REQ-003 Port clk, input, 1: single clock, rising edge.
REQ-004 Port rst_n, input, 1: reset, asynchronous and active-low.
REQ-005 Port start, input, 1: launch-schedule pulse, sampled only in IDLE.
REQ-006 Port abort, input, 1: cancels a running schedule.
REQ-007 Port init_val, input, N_CH: value loaded into ch_out on launch.
REQ-008 Port tgt_val, input, N_CH: value each channel takes when its delay expires.
REQ-009 Port ch_dly, input, N_CH*DLY_W: per-channel delay; channel i occupies bits [i*DLY_W +: DLY_W].
REQ-010 Port snap_dly, input, DLY_W: snapshot delay.
REQ-011 Port ch_out, output, N_CH: current channel values.
REQ-012 Port snap_out, output, N_CH: captured copy of ch_out.
REQ-013 Port snap_vld, output, 1: high from snapshot capture until the next launch or reset.
REQ-014 Port busy, output, 1: high while in RUN.
REQ-015 Port done, output, 1: one-cycle pulse when a schedule completes.
REQ-016 Port tick, output, DLY_W: current RUN-cycle count.

Function
REQ-017 The FSM SHALL have three states: IDLE, RUN and DONE.
REQ-018 IDLE with start=1 and abort=0 SHALL perform a launch: latch tgt_val, ch_dly and snap_dly; ch_out<=init_val; tick<=0; clear all fired flags; snap_vld<=0; go to RUN.
REQ-019 Configuration inputs SHALL be ignored outside a launch cycle, so changes during RUN have no effect.
REQ-020 In RUN, for each channel i with tick==dly[i] and fired[i]=0, ch_out[i]<=tgt[i] and fired[i]<=1.
REQ-021 A delay of 0 SHALL fire in the first RUN cycle, one clock after the launch edge.
REQ-022 In RUN with tick==snap_dly, snap_out<=ch_out (the pre-update register value) and snap_vld<=1.
REQ-023 A channel event and the snapshot in the same cycle SHALL leave the old channel value in snap_out (non-blocking semantics).
REQ-024 Channels firing in the same cycle SHALL all update in that cycle.
REQ-025 tick SHALL increment by 1 in every RUN cycle.
REQ-026 RUN SHALL go to DONE in the cycle where all channels have fired and the snapshot is taken or already taken.
REQ-027 tick SHALL never wrap, because completion occurs no later than tick==2^DLY_W-1.
REQ-028 DONE SHALL assert done for exactly one cycle, then go to IDLE; ch_out, snap_out and tick hold.
REQ-029 start while in RUN or DONE SHALL be ignored.
REQ-030 abort in RUN SHALL go to IDLE next cycle with done=0; ch_out holds its partial values and snap_vld holds.
REQ-031 start and abort together in IDLE: abort SHALL win and no launch occurs.
REQ-032 busy SHALL equal (state==RUN).

Reset
REQ-033 rst_n low SHALL immediately force IDLE and ch_out=0, snap_out=0, snap_vld=0, busy=0, done=0, tick=0, and clear all fired flags.
REQ-034 Reset mid-RUN SHALL discard the schedule; after release the block waits for a new start.

Configuration
REQ-035 Macro DELAY_SCHEDULER_SNAP_EN defined SHALL include the snapshot logic described in REQ-022/023.
REQ-036 Macro DELAY_SCHEDULER_SNAP_EN undefined SHALL hold snap_out=0 and snap_vld=0 permanently, ignore snap_dly, and complete on the last channel event alone.

Structure
REQ-037 Package delay_scheduler_pkg SHALL hold the FSM state enum (IDLE/RUN/DONE) and the default parameter constants.
REQ-038 Sub-module ds_channel (one instance per channel) SHALL hold one channel's delay compare, fired flag and output register.

Verification
REQ-039 Basic schedule: N_CH=3, init=000, tgt={a=0,b=1,c=0} on ch_out[2:0], dly={a:0,b:10,c:5}, snap_dly=20 -> ch_out[1] rises at RUN cycle 10, snap_out=010, done 1 cycle after the snapshot cycle.
REQ-040 Same-cycle collision: ch1 dly=10 tgt=1, snap_dly=10, init=0 -> snap_out[1]=0, ch_out[1]=1.
REQ-041 Abort at tick=7 with ch1 dly=10 -> busy drops, done stays 0, ch_out[1] keeps its init value.
REQ-042 Reset asserted at tick=4 -> all outputs 0 asynchronously; a start after release runs a full schedule.
REQ-043 Boundary: all delays 0 and snap_dly=0 -> snap_out=init_val, done pulses at RUN cycle 1; with all delays 255 at DLY_W=8 -> completion at tick=255 with no wrap.
REQ-044 Ignored launch: start held during RUN -> no relaunch, tick is monotonic; rerun with the macro undefined -> snap_vld never asserts.
